// File: rtl/mem_dump_engine_if.sv
// Memory read port and UART TX byte port of the dump engine, grouped as one bundle.
// master = engine side, slave = SRAM model / transmitter side.
interface mem_dump_engine_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              mem_oe_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (
    output mem_oe_n, mem_addr, tx_start, tx_data,
    input  mem_rd, tx_busy
  );

  modport slave (
    input  mem_oe_n, mem_addr, tx_start, tx_data,
    output mem_rd, tx_busy
  );
endinterface

// File: rtl/mem_dump_engine.sv
// Memory-dump sequencer: reads an inclusive word range and streams it to the UART as hex lines or raw bytes.
// One read per word (1-cycle latency), at least 2 cycles per byte; holds a byte while tx_busy is high.

module syncd01a (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module mem_dump_engine #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int ADDR_PREFIX = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                dump_kick,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                mode_raw,
  input  logic                abort,
  output logic                busy,
  output logic                dump_done,
  output logic                aborted,
  output logic [ADDR_W-1:0]   rest,
  mem_dump_engine_if.master   bus
);
  localparam int NB      = DATA_W / 8;
  localparam int AD      = (ADDR_W + 3) / 4;
  localparam int PRE     = (ADDR_PREFIX != 0) ? AD + 2 : 0;
  localparam int HEX_LEN = PRE + 3 * NB;
  localparam int CW      = $clog2(HEX_LEN + 1);

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, SEND_GAP, NEXT, DONE} state_t;

  state_t            state, state_nxt;
  logic              kick_s, kick_d, kick_rise;
  logic [ADDR_W-1:0] cur, end_q;
  logic              raw_q, abort_q, abort_seen, accept, send;
  logic [DATA_W-1:0] word;
  logic [CW-1:0]     char_idx, hex_j, line_len;
  logic [4*AD-1:0]   cur_pad;
  logic [7:0]        ch;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  syncd01a u_kick_sync (.clk(clk), .reset_n(reset_n), .d(dump_kick), .q(kick_s));

  assign accept     = kick_rise && (state == IDLE || state == DONE);
  assign abort_seen = abort_q || abort;
  assign send       = (state == SEND) && !bus.tx_busy;
  assign line_len   = raw_q ? CW'(NB) : CW'(HEX_LEN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = (start_addr > end_addr) ? DONE : READ;
      READ:       state_nxt = abort_seen ? DONE : LATCH;
      LATCH:      state_nxt = abort_seen ? DONE : SEND;
      SEND:       if (!bus.tx_busy) state_nxt = SEND_GAP;
      SEND_GAP:   state_nxt = (char_idx != line_len) ? SEND : NEXT;
      NEXT:       state_nxt = (abort_seen || cur == end_q) ? DONE : READ;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = !(state == IDLE || state == DONE);
    dump_done    = (state == DONE);
    aborted      = (state == DONE) && abort_q;
    bus.mem_oe_n = (state != READ);
    bus.mem_addr = cur;
    bus.tx_start = send;
    bus.tx_data  = send ? ch : 8'h00;
    rest         = busy ? (end_q - cur) : '0;
  end

  // Kick edge detect is registered so its delay is fixed at one cycle after the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kick_d    <= 1'b0;
      kick_rise <= 1'b0;
      cur       <= '0;
      end_q     <= '0;
      raw_q     <= 1'b0;
      abort_q   <= 1'b0;
      word      <= '0;
      char_idx  <= '0;
    end else begin
      kick_d    <= kick_s;
      kick_rise <= kick_s && !kick_d;
      if (accept) begin
        cur     <= start_addr;
        end_q   <= end_addr;
        raw_q   <= mode_raw;
        abort_q <= 1'b0;
      end else if (busy) begin
        abort_q <= abort_q || abort;
      end
      if (state == LATCH) begin
        word     <= bus.mem_rd;
        char_idx <= '0;
      end
      if (send) char_idx <= char_idx + 1'b1;
      if (state == NEXT && !abort_seen && cur != end_q) cur <= cur + 1'b1;
    end
  end

  // Character for the current position, derived from char_idx alone (no line buffer).
  always_comb begin
    ch      = 8'h00;
    cur_pad = (4*AD)'(cur);
    hex_j   = char_idx - CW'(PRE);
    if (raw_q) begin
      for (int b = 0; b < NB; b++)
        if (char_idx == CW'(b)) ch = word[8*b +: 8];
    end else begin
      for (int p = 0; p < PRE - 2; p++)
        if (char_idx == CW'(p)) ch = hex_digit(cur_pad[4*(AD-1-p) +: 4]);
      if (PRE != 0) begin
        if (char_idx == CW'(PRE - 2)) ch = 8'h3A;
        if (char_idx == CW'(PRE - 1)) ch = 8'h20;
      end
      for (int b = 0; b < NB; b++) begin
        if (hex_j == CW'(3*b))     ch = hex_digit(word[8*b+4 +: 4]);
        if (hex_j == CW'(3*b + 1)) ch = hex_digit(word[8*b +: 4]);
        if (hex_j == CW'(3*b + 2)) ch = (b == NB - 1) ? 8'h0A : 8'h20;
      end
    end
  end
endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench: three engine variants (32-bit hex, 32-bit hex with address prefix, 16-bit) run the same dumps.
module tb_mem_dump_engine;
  typedef logic [7:0] bq_t [$];

  logic        clk, reset_n, dump_kick, mode_raw, abort;
  logic [17:0] start_addr, end_addr;
  logic        busy_a, done_a, ab_a, busy_b, done_b, ab_b, busy_c, done_c, ab_c;
  logic [17:0] rest_a, rest_b, rest_c;

  int          n_checks, n_errors, gap;
  int          cnt_a, cnt_b, cnt_c, rd_a, rd_b, rd_c, viol_a, viol_b, viol_c;
  int          ba, bb, bc, bra, rda0, rdb0, rdc0;
  bq_t         qa, qb, qc;
  logic [17:0] ra [$];

  mem_dump_engine_if #(.ADDR_W(18), .DATA_W(32)) ifa ();
  mem_dump_engine_if #(.ADDR_W(18), .DATA_W(32)) ifb ();
  mem_dump_engine_if #(.ADDR_W(18), .DATA_W(16)) ifc ();

  mem_dump_engine #(.ADDR_W(18), .DATA_W(32), .ADDR_PREFIX(0)) u_a (
    .clk(clk), .reset_n(reset_n), .dump_kick(dump_kick), .start_addr(start_addr),
    .end_addr(end_addr), .mode_raw(mode_raw), .abort(abort), .busy(busy_a),
    .dump_done(done_a), .aborted(ab_a), .rest(rest_a), .bus(ifa));
  mem_dump_engine #(.ADDR_W(18), .DATA_W(32), .ADDR_PREFIX(1)) u_b (
    .clk(clk), .reset_n(reset_n), .dump_kick(dump_kick), .start_addr(start_addr),
    .end_addr(end_addr), .mode_raw(mode_raw), .abort(abort), .busy(busy_b),
    .dump_done(done_b), .aborted(ab_b), .rest(rest_b), .bus(ifb));
  mem_dump_engine #(.ADDR_W(18), .DATA_W(16), .ADDR_PREFIX(0)) u_c (
    .clk(clk), .reset_n(reset_n), .dump_kick(dump_kick), .start_addr(start_addr),
    .end_addr(end_addr), .mode_raw(mode_raw), .abort(abort), .busy(busy_c),
    .dump_done(done_c), .aborted(ab_c), .rest(rest_c), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [17:0] a);
    case (a)
      18'h00010: return 32'hDEADBEEF;
      18'h00011: return 32'h0F1E2D3C;
      18'h3FFFF: return 32'hCAFE1234;
      default:   return 32'h00000000;
    endcase
  endfunction

  function automatic logic [15:0] memw16(input logic [17:0] a);
    logic [31:0] w;
    w = memw(a);
    return w[15:0];
  endfunction

  assign ifa.tx_busy = (cnt_a != 0);
  assign ifb.tx_busy = (cnt_b != 0);
  assign ifc.tx_busy = (cnt_c != 0);

  // SRAM with one-cycle read latency plus a transmitter that stays busy for 'gap' cycles per byte.
  always @(posedge clk) begin
    if (!ifa.mem_oe_n) begin ifa.mem_rd <= memw(ifa.mem_addr); rd_a <= rd_a + 1; ra.push_back(rest_a); end
    if (ifa.tx_start) begin
      if (ifa.tx_busy) viol_a <= viol_a + 1;
      qa.push_back(ifa.tx_data); cnt_a <= gap;
    end else if (cnt_a > 0) cnt_a <= cnt_a - 1;
  end
  always @(posedge clk) begin
    if (!ifb.mem_oe_n) begin ifb.mem_rd <= memw(ifb.mem_addr); rd_b <= rd_b + 1; end
    if (ifb.tx_start) begin
      if (ifb.tx_busy) viol_b <= viol_b + 1;
      qb.push_back(ifb.tx_data); cnt_b <= gap;
    end else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  always @(posedge clk) begin
    if (!ifc.mem_oe_n) begin ifc.mem_rd <= memw16(ifc.mem_addr); rd_c <= rd_c + 1; end
    if (ifc.tx_start) begin
      if (ifc.tx_busy) viol_c <= viol_c + 1;
      qc.push_back(ifc.tx_data); cnt_c <= gap;
    end else if (cnt_c > 0) cnt_c <= cnt_c - 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_text(input string tag, input bq_t q, input int base, input string exp);
    check({tag, "_len"}, q.size() - base, exp.len());
    for (int i = 0; i < exp.len(); i++)
      if (base + i < q.size()) check(tag, q[base + i], exp[i]);
  endtask

  task automatic check_raw(input string tag, input bq_t q, input int base, input int n, input logic [31:0] w);
    check({tag, "_len"}, q.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < q.size()) check(tag, q[base + i], w[8*i +: 8]);
  endtask

  // Kick a dump, optionally pulse abort once A has emitted abort_after bytes, then wait for all three DONE.
  task automatic run_dump(input logic [17:0] s, input logic [17:0] e, input logic raw,
                          input int g, input int abort_after);
    ba = qa.size(); bb = qb.size(); bc = qc.size(); bra = ra.size();
    rda0 = rd_a; rdb0 = rd_b; rdc0 = rd_c;
    gap = g; start_addr = s; end_addr = e; mode_raw = raw;
    dump_kick = 1'b1;
    repeat (3) @(negedge clk);
    dump_kick = 1'b0;
    repeat (4) @(negedge clk);
    if (abort_after >= 0) begin
      for (int i = 0; i < 2000 && qa.size() < ba + abort_after; i++) @(negedge clk);
      check("abort_point", qa.size() - ba, abort_after);
      check("abort_tx_busy", ifa.tx_busy, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    for (int i = 0; i < 5000 && !(done_a && done_b && done_c); i++) @(negedge clk);
    check("done_timeout", {done_a, done_b, done_c}, 3'b111);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; gap = 0;
    reset_n = 1'b0; dump_kick = 1'b0; mode_raw = 1'b0; abort = 1'b0;
    start_addr = '0; end_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_aborted", ab_a, 1'b0);
    check("rst_oe_n", ifa.mem_oe_n, 1'b1);
    check("rst_addr", ifa.mem_addr, 18'h0);
    check("rst_rest", rest_a, 18'h0);
    check("rst_tx_start", ifb.tx_start, 1'b0);
    check("rst_tx_data", ifb.tx_data, 8'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word hex dump; B carries the address prefix, C dumps 16-bit words.
    run_dump(18'h00010, 18'h00011, 1'b0, 1, -1);
    check_text("hexA", qa, ba, "EF BE AD DE\n3C 2D 1E 0F\n");
    check_text("hexB", qb, bb, "00010: EF BE AD DE\n00011: 3C 2D 1E 0F\n");
    check_text("hexC", qc, bc, "EF BE\n3C 2D\n");
    check("hex_reads", rd_a - rda0, 2);
    check("hex_rest_n", ra.size() - bra, 2);
    if (ra.size() >= bra + 2) begin
      check("hex_rest0", ra[bra], 18'd1);
      check("hex_rest1", ra[bra + 1], 18'd0);
    end
    check("hex_aborted", ab_a, 1'b0);
    check("hex_busy_off", busy_a, 1'b0);
    check("hex_rest_idle", rest_a, 18'h0);

    // Raw dump of the top address: exactly one read and no wrap.
    run_dump(18'h3FFFF, 18'h3FFFF, 1'b1, 2, -1);
    check_raw("rawA", qa, ba, 4, 32'hCAFE1234);
    check_raw("rawB", qb, bb, 4, 32'hCAFE1234);
    check_raw("rawC", qc, bc, 2, 32'h00001234);
    check("top_reads", rd_a - rda0, 1);
    check("top_reads_c", rd_c - rdc0, 1);
    check("top_rest", ra[bra], 18'd0);

    // Empty range: no reads, no bytes.
    run_dump(18'd5, 18'd4, 1'b0, 0, -1);
    check("empty_reads", rd_a - rda0, 0);
    check("empty_tx", qa.size() - ba, 0);
    check("empty_done", done_a, 1'b1);
    check("empty_aborted", ab_a, 1'b0);

    // Abort mid-line: current line finishes, no second word is read.
    run_dump(18'h00010, 18'h00011, 1'b0, 6, 3);
    check_text("abtA", qa, ba, "EF BE AD DE\n");
    check_text("abtB", qb, bb, "00010: EF BE AD DE\n");
    check_text("abtC", qc, bc, "EF BE\n");
    check("abt_reads", rd_a - rda0, 1);
    check("abt_reads_b", rd_b - rdb0, 1);
    check("abt_flags", {ab_a, ab_b, ab_c}, 3'b111);
    check("abt_done", done_a, 1'b1);

    // A fresh kick restarts cleanly with aborted cleared.
    run_dump(18'h00010, 18'h00010, 1'b1, 0, -1);
    check_raw("rekickA", qa, ba, 4, 32'hDEADBEEF);
    check("rekick_aborted", {ab_a, ab_b, ab_c}, 3'b000);
    check("rekick_reads", rd_a - rda0, 1);

    check("tx_during_busy", viol_a + viol_b + viol_c, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
